// File: rtl/hdmi_data_island_decoder.sv
// HDMI data-island packet decoder: reassembles 32-cycle TERC4-decoded packets,
// verifies header/subpacket BCH parity and extracts stereo PCM from audio packets.
module hdmi_data_island_decoder #(
    parameter logic [7:0] AUDIO_TYPE = 8'h02,
    parameter bit         DROP_BAD   = 1'b1
) (
    input  logic           i_pixclk,
    input  logic           i_rst_n,
    input  logic           i_data,
    input  logic [3:0]     i_d0,
    input  logic [3:0]     i_d1,
    input  logic [3:0]     i_d2,
    output logic           o_hsync,
    output logic           o_vsync,
    output logic           o_pkt_valid,
    output logic [23:0]    o_pkt_hdr,
    output logic [223:0]   o_pkt_body,
    output logic           o_hdr_err,
    output logic [3:0]     o_sub_err,
    output logic           o_trunc,
    output logic           o_sample_valid,
    output logic [15:0]    o_audioL,
    output logic [15:0]    o_audioR
);
    typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_e;

    function automatic logic [7:0] bch_step(input logic [7:0] code, input logic b);
        return {code[6:0], 1'b0} ^ ((code[7] ^ b) ? 8'hC1 : 8'h00);
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic             data_q, data_d;
    logic [4:0]       off_q, off_d;
    logic [23:0]      hdr_q, hdr_d;
    logic [7:0]       hpar_q, hpar_d, hecc_q, hecc_d;
    logic [3:0][55:0] sub_q, sub_d;
    logic [3:0][7:0]  spar_q, spar_d, secc_q, secc_d;

    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic [23:0]      pkt_hdr_q, pkt_hdr_d;
    logic [3:0][55:0] pkt_body_q, pkt_body_d;
    logic             hdr_err_q, hdr_err_d;
    logic [3:0]       sub_err_q, sub_err_d;
    logic             trunc_q, trunc_d;
    logic             sample_valid_q, sample_valid_d;
    logic [15:0]      audio_l_q, audio_l_d, audio_r_q, audio_r_d;

    logic [4:0]       cur_off;
    logic             restart;
    logic [7:0]       hbase;
    logic [3:0]       present;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d        = state_q;
        k_d            = k_q;
        data_d         = i_data;
        off_d          = off_q;
        hdr_d          = hdr_q;
        hpar_d         = hpar_q;
        hecc_d         = hecc_q;
        sub_d          = sub_q;
        spar_d         = spar_q;
        secc_d         = secc_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;
        pkt_valid_d    = 1'b0;
        pkt_hdr_d      = pkt_hdr_q;
        pkt_body_d     = pkt_body_q;
        hdr_err_d      = hdr_err_q;
        sub_err_d      = sub_err_q;
        trunc_d        = 1'b0;
        sample_valid_d = 1'b0;
        audio_l_d      = audio_l_q;
        audio_r_d      = audio_r_q;

        restart = i_data && (!data_q || !i_d0[3]);
        cur_off = restart ? 5'd0 : off_q;
        hbase   = (cur_off == 5'd0) ? 8'h00 : hecc_q;
        present = pkt_hdr_q[11:8];

        // A partial packet is abandoned when the island ends or a resync arrives early.
        if (data_q && off_q != 5'd0 && (!i_data || !i_d0[3]))
            trunc_d = 1'b1;

        if (i_data) begin
            hsync_d = i_d0[0];
            vsync_d = i_d0[1];
            off_d   = cur_off + 5'd1;
            if (cur_off < 5'd24) begin
                hdr_d[cur_off] = i_d0[2];
                hecc_d         = bch_step(hbase, i_d0[2]);
            end else begin
                hpar_d[~cur_off[2:0]] = i_d0[2];
            end
            for (int k = 0; k < 4; k++) begin
                if (cur_off < 5'd28) begin
                    sub_d[k][{cur_off, 1'b0}] = i_d1[k];
                    sub_d[k][{cur_off, 1'b1}] = i_d2[k];
                    secc_d[k] = bch_step(bch_step((cur_off == 5'd0) ? 8'h00 : secc_q[k],
                                                  i_d1[k]), i_d2[k]);
                end else begin
                    spar_d[k][{~cur_off[1:0], 1'b1}] = i_d1[k];
                    spar_d[k][{~cur_off[1:0], 1'b0}] = i_d2[k];
                end
            end
            if (cur_off == 5'd31) begin
                pkt_valid_d = 1'b1;
                pkt_hdr_d   = hdr_d;
                pkt_body_d  = sub_d;
                hdr_err_d   = (hpar_d != hecc_d);
                for (int k = 0; k < 4; k++)
                    sub_err_d[k] = (spar_d[k] != secc_d[k]);
            end
        end

        case (state_q)
            IDLE: if (i_data) state_d = COLLECT;
            COLLECT: begin
                if (pkt_valid_d && pkt_hdr_d[7:0] == AUDIO_TYPE && !hdr_err_d) begin
                    state_d = EMIT;
                    k_d     = 2'd0;
                end else if (!i_data) begin
                    state_d = IDLE;
                end
            end
            EMIT: begin
                // The output packet registers double as the snapshot being scanned.
                if (present[k_q] && !(DROP_BAD && sub_err_q[k_q])) begin
                    sample_valid_d = 1'b1;
                    audio_l_d      = pkt_body_q[k_q][23:8];
                    audio_r_d      = pkt_body_q[k_q][47:32];
                end
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = i_data ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge i_pixclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            k_q            <= '0;
            data_q         <= 1'b0;
            off_q          <= '0;
            hdr_q          <= '0;
            hpar_q         <= '0;
            hecc_q         <= '0;
            sub_q          <= '0;
            spar_q         <= '0;
            secc_q         <= '0;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
            pkt_valid_q    <= 1'b0;
            pkt_hdr_q      <= '0;
            pkt_body_q     <= '0;
            hdr_err_q      <= 1'b0;
            sub_err_q      <= '0;
            trunc_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            audio_l_q      <= '0;
            audio_r_q      <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            data_q         <= data_d;
            off_q          <= off_d;
            hdr_q          <= hdr_d;
            hpar_q         <= hpar_d;
            hecc_q         <= hecc_d;
            sub_q          <= sub_d;
            spar_q         <= spar_d;
            secc_q         <= secc_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            pkt_valid_q    <= pkt_valid_d;
            pkt_hdr_q      <= pkt_hdr_d;
            pkt_body_q     <= pkt_body_d;
            hdr_err_q      <= hdr_err_d;
            sub_err_q      <= sub_err_d;
            trunc_q        <= trunc_d;
            sample_valid_q <= sample_valid_d;
            audio_l_q      <= audio_l_d;
            audio_r_q      <= audio_r_d;
        end
    end

    assign o_hsync        = hsync_q;
    assign o_vsync        = vsync_q;
    assign o_pkt_valid    = pkt_valid_q;
    assign o_pkt_hdr      = pkt_hdr_q;
    assign o_pkt_body     = pkt_body_q;
    assign o_hdr_err      = hdr_err_q;
    assign o_sub_err      = sub_err_q;
    assign o_trunc        = trunc_q;
    assign o_sample_valid = sample_valid_q;
    assign o_audioL       = audio_l_q;
    assign o_audioR       = audio_r_q;
endmodule

// File: tb/tb_hdmi_data_island_decoder.sv
// Self-checking bench for hdmi_data_island_decoder: directed vector table,
// multi-cycle corner sequences and randomized packets against a packet-level model.
module tb_hdmi_data_island_decoder;
    localparam logic [7:0] AUDIO_TYPE = 8'h02;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_data;
    logic [3:0]     i_d0, i_d1, i_d2;
    logic           o_hsync, o_vsync, o_pkt_valid, o_hdr_err, o_trunc, o_sample_valid;
    logic [23:0]    o_pkt_hdr;
    logic [223:0]   o_pkt_body;
    logic [3:0]     o_sub_err;
    logic [15:0]    o_audioL, o_audioR;

    always #5 clk = ~clk;

    hdmi_data_island_decoder #(.AUDIO_TYPE(AUDIO_TYPE), .DROP_BAD(1'b1)) dut (
        .i_pixclk(clk), .i_rst_n(rst_n), .i_data(i_data),
        .i_d0(i_d0), .i_d1(i_d1), .i_d2(i_d2),
        .o_hsync(o_hsync), .o_vsync(o_vsync), .o_pkt_valid(o_pkt_valid),
        .o_pkt_hdr(o_pkt_hdr), .o_pkt_body(o_pkt_body), .o_hdr_err(o_hdr_err),
        .o_sub_err(o_sub_err), .o_trunc(o_trunc), .o_sample_valid(o_sample_valid),
        .o_audioL(o_audioL), .o_audioR(o_audioR)
    );

    typedef struct {
        logic [23:0]  hdr;
        logic [223:0] body;
        logic         herr;
        logic [3:0]   serr;
        int           at;
    } pkt_t;

    typedef struct {
        logic [23:0] hdr;
        logic [55:0] s0;
        logic [55:0] s1;
        logic [23:0] hflip;
        logic [55:0] s1flip;
        logic        exp_herr;
        logic [3:0]  exp_serr;
        int          exp_nsmp;
        logic [31:0] exp_smp0;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          trunc_cnt = 0;
    pkt_t        got_pkt[$], exp_pkt[$];
    logic [31:0] got_smp[$], exp_smp[$];
    logic        last_hs, last_vs;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pkt_t p;
        if (o_pkt_valid) begin
            p.hdr = o_pkt_hdr; p.body = o_pkt_body; p.herr = o_hdr_err;
            p.serr = o_sub_err; p.at = cyc;
            got_pkt.push_back(p);
        end
        if (o_sample_valid) got_smp.push_back({o_audioL, o_audioR});
        if (o_trunc) trunc_cnt++;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // BCH parity of the first n data bits, taken in transmit order (bit 0 first).
    function automatic logic [7:0] bch(input logic [55:0] bits, input int n);
        logic [7:0] code = 8'h00;
        for (int i = 0; i < n; i++)
            code = {code[6:0], 1'b0} ^ ((code[7] ^ bits[i]) ? 8'hC1 : 8'h00);
        return code;
    endfunction

    // Drives nsym symbols of one packet; a full packet also records the model's expectations.
    task automatic send_packet(input logic [23:0] hdr, input logic [3:0][55:0] sub,
                               input logic [23:0] hflip, input logic [3:0][55:0] sflip,
                               input bit first, input int nsym);
        logic [7:0]       hecc;
        logic [3:0][7:0]  secc;
        logic [23:0]      thdr;
        logic [3:0][55:0] tsub;
        pkt_t             e;
        hecc = bch({32'h0, hdr}, 24);
        for (int k = 0; k < 4; k++) secc[k] = bch(sub[k], 56);
        thdr = hdr ^ hflip;
        tsub = sub ^ sflip;
        for (int off = 0; off < nsym; off++) begin
            @(posedge clk); #1;
            if (off == 0) e.at = cyc + 32;
            last_hs = 1'($urandom_range(1, 0));
            last_vs = 1'($urandom_range(1, 0));
            i_data = 1'b1;
            i_d0[0] = last_hs;
            i_d0[1] = last_vs;
            i_d0[2] = (off < 24) ? thdr[off] : hecc[31 - off];
            i_d0[3] = !(off == 0 && first);
            for (int k = 0; k < 4; k++) begin
                i_d1[k] = (off < 28) ? tsub[k][2*off]     : secc[k][7 - 2*(off-28)];
                i_d2[k] = (off < 28) ? tsub[k][2*off + 1] : secc[k][6 - 2*(off-28)];
            end
        end
        if (nsym == 32) begin
            e.hdr  = thdr;
            e.body = tsub;
            e.herr = (bch({32'h0, thdr}, 24) != hecc);
            for (int k = 0; k < 4; k++) e.serr[k] = (bch(tsub[k], 56) != secc[k]);
            exp_pkt.push_back(e);
            if (thdr[7:0] == AUDIO_TYPE && !e.herr)
                for (int k = 0; k < 4; k++)
                    if (thdr[8+k] && !e.serr[k]) exp_smp.push_back({tsub[k][23:8], tsub[k][47:32]});
        end
    endtask

    task automatic end_island(input int idle);
        @(posedge clk); #1;
        i_data = 1'b0; i_d0 = 4'h0; i_d1 = 4'h0; i_d2 = 4'h0;
        repeat (idle) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_all();
        got_pkt.delete(); exp_pkt.delete(); got_smp.delete(); exp_smp.delete();
        trunc_cnt = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_npkt"}, got_pkt.size(), exp_pkt.size());
        for (int i = 0; i < got_pkt.size() && i < exp_pkt.size(); i++) begin
            check({tag, "_hdr"},  got_pkt[i].hdr,  exp_pkt[i].hdr);
            check({tag, "_body"}, got_pkt[i].body, exp_pkt[i].body);
            check({tag, "_herr"}, got_pkt[i].herr, exp_pkt[i].herr);
            check({tag, "_serr"}, got_pkt[i].serr, exp_pkt[i].serr);
            check({tag, "_lat"},  got_pkt[i].at,   exp_pkt[i].at);
        end
        check({tag, "_nsmp"}, got_smp.size(), exp_smp.size());
        for (int i = 0; i < got_smp.size() && i < exp_smp.size(); i++)
            check({tag, "_smp"}, got_smp[i], exp_smp[i]);
        check({tag, "_hsync"}, o_hsync, last_hs);
        check({tag, "_vsync"}, o_vsync, last_vs);
    endtask

    logic [3:0][55:0] zsub, sub, flip;
    vec_t             vecs[4];
    logic [55:0]      s_audio0, s_audio1;

    initial begin
        s_audio0 = 56'h00ABCD00123400;
        s_audio1 = 56'h007FFF00800000;
        vecs[0] = '{24'h0D0282, 56'h00000000191046, 56'h0, 24'h0, 56'h0, 1'b0, 4'b0000, 0, 32'h0};
        vecs[1] = '{24'h100302, s_audio0, s_audio1, 24'h0, 56'h0, 1'b0, 4'b0000, 2, 32'h1234ABCD};
        vecs[2] = '{24'h100302, s_audio0, s_audio1, 24'h000020, 56'h0, 1'b1, 4'b0000, 0, 32'h0};
        vecs[3] = '{24'h100302, s_audio0, s_audio1, 24'h0, 56'h400, 1'b0, 4'b0010, 1, 32'h1234ABCD};
        zsub = '0;
        last_hs = 1'b0; last_vs = 1'b0;

        rst_n = 1'b0; i_data = 1'b0; i_d0 = 4'h0; i_d1 = 4'h0; i_d2 = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", |{o_hsync, o_vsync, o_pkt_valid, o_pkt_hdr, o_pkt_body, o_hdr_err,
                                 o_sub_err, o_trunc, o_sample_valid, o_audioL, o_audioR}, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed vectors, one packet per island.
        for (int v = 0; v < 4; v++) begin
            clear_all();
            sub = '0; sub[0] = vecs[v].s0; sub[1] = vecs[v].s1;
            flip = '0; flip[1] = vecs[v].s1flip;
            send_packet(vecs[v].hdr, sub, vecs[v].hflip, flip, 1'b1, 32);
            end_island(8);
            check($sformatf("vec%0d_npkt", v), got_pkt.size(), 1);
            if (got_pkt.size() > 0) begin
                check($sformatf("vec%0d_herr", v), got_pkt[0].herr, vecs[v].exp_herr);
                check($sformatf("vec%0d_serr", v), got_pkt[0].serr, vecs[v].exp_serr);
            end
            check($sformatf("vec%0d_nsmp", v), got_smp.size(), vecs[v].exp_nsmp);
            if (vecs[v].exp_nsmp > 0 && got_smp.size() > 0)
                check($sformatf("vec%0d_smp0", v), got_smp[0], vecs[v].exp_smp0);
            compare_all($sformatf("vec%0d", v));
        end

        // Back-to-back ACR + audio packets in one 64-cycle island.
        clear_all();
        sub = '0; sub[0] = s_audio0; sub[1] = s_audio1;
        send_packet(24'h000001, zsub, 24'h0, zsub, 1'b1, 32);
        send_packet(24'h100302, sub, 24'h0, zsub, 1'b0, 32);
        end_island(8);
        if (got_pkt.size() == 2) check("b2b_gap", got_pkt[1].at - got_pkt[0].at, 32);
        check("b2b_smp1", (got_smp.size() > 1) ? got_smp[1] : 32'h0, 32'h80007FFF);
        check("b2b_trunc", trunc_cnt, 0);
        compare_all("b2b");

        // Island drops at offset 17, then a clean island.
        clear_all();
        send_packet(24'h100302, sub, 24'h0, zsub, 1'b1, 17);
        end_island(8);
        check("drop_trunc", trunc_cnt, 1);
        check("drop_npkt", got_pkt.size(), 0);
        clear_all();
        send_packet(24'h100302, sub, 24'h0, zsub, 1'b1, 32);
        end_island(8);
        check("after_drop_trunc", trunc_cnt, 0);
        compare_all("after_drop");

        // Resync after 10 symbols inside one island restarts a packet on the same cycle.
        clear_all();
        send_packet(24'h0D0282, zsub, 24'h0, zsub, 1'b1, 10);
        send_packet(24'h100302, sub, 24'h0, zsub, 1'b1, 32);
        end_island(8);
        check("resync_trunc", trunc_cnt, 1);
        compare_all("resync");

        // Reset mid-packet at offset 10.
        clear_all();
        send_packet(24'h100302, sub, 24'h0, zsub, 1'b1, 10);
        @(posedge clk); #1;
        rst_n = 1'b0; i_data = 1'b0; i_d0 = 4'h0; i_d1 = 4'h0; i_d2 = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_outputs", |{o_hsync, o_vsync, o_pkt_valid, o_pkt_hdr, o_pkt_body, o_hdr_err,
                                  o_sub_err, o_trunc, o_sample_valid, o_audioL, o_audioR}, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        clear_all();
        send_packet(24'h100302, sub, 24'h0, zsub, 1'b1, 32);
        end_island(8);
        check("midrst_trunc", trunc_cnt, 0);
        compare_all("midrst");

        // Randomized islands of one or two packets checked against the model.
        for (int it = 0; it < 40; it++) begin
            int np;
            clear_all();
            np = $urandom_range(2, 1);
            for (int p = 0; p < np; p++) begin
                logic [23:0] hdr, hf;
                logic [63:0] r;
                hdr = 24'($urandom());
                if ($urandom_range(1, 0) == 1) hdr[7:0] = AUDIO_TYPE;
                hf = ($urandom_range(3, 0) == 0) ? (24'h1 << $urandom_range(23, 0)) : 24'h0;
                for (int k = 0; k < 4; k++) begin
                    r = {$urandom(), $urandom()};
                    sub[k] = r[55:0];
                    flip[k] = ($urandom_range(3, 0) == 0) ? (56'h1 << $urandom_range(55, 0)) : 56'h0;
                end
                send_packet(hdr, sub, hf, flip, p == 0, 32);
            end
            end_island(8);
            check("rand_trunc", trunc_cnt, 0);
            compare_all($sformatf("rand%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hdmi_data_island_decoder.md
Name: hdmi_data_island_decoder

Overview:
- Receive-side counterpart of the HDMI data-island encoder; sits after the TERC4 symbol decoder in the HDMI capture path.
- Takes the three 4-bit TERC4-decoded channel nibbles per pixel clock while a data island is active.
- Reassembles each 32-cycle packet into its 24-bit header and four 56-bit subpackets, and checks the BCH ECC.
- Extracts 16-bit stereo PCM samples from audio sample packets.

Parameters:
- AUDIO_TYPE, 8'h02, header byte 0 value identifying an audio sample packet.
- DROP_BAD, 1, when 1 no audio samples are emitted from a subpacket whose ECC failed.

Ports:
- i_pixclk  in  1  pixel clock; all logic on its rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_data  in  1  high while the current cycle carries a data-island TERC4 symbol.
- i_d0  in  4  channel 0 nibble: [0]=hsync, [1]=vsync, [2]=header bit, [3]=0 only on the first cycle of an island.
- i_d1  in  4  channel 1 nibble: bit [k] = even bit of subpacket k.
- i_d2  in  4  channel 2 nibble: bit [k] = odd bit of subpacket k.
- o_hsync  out  1  last hsync seen during an island.
- o_vsync  out  1  last vsync seen during an island.
- o_pkt_valid  out  1  one-cycle pulse: packet outputs are valid.
- o_pkt_hdr  out  24  received header bits 23:0.
- o_pkt_body  out  224  {sub3,sub2,sub1,sub0}, 56 bits each.
- o_hdr_err  out  1  header BCH mismatch; valid with o_pkt_valid.
- o_sub_err  out  4  per-subpacket BCH mismatch; valid with o_pkt_valid.
- o_trunc  out  1  one-cycle pulse: island ended or resynced mid-packet.
- o_sample_valid  out  1  one-cycle pulse per extracted audio sample.
- o_audioL  out  16  left sample = subpacket bits 23:8.
- o_audioR  out  16  right sample = subpacket bits 47:32.

Behaviour:
- Reset: every output and all internal state go to 0; the FSM enters IDLE.
- Offset counter (5 bit):
  - Loads 0 on the cycle i_data rises, or on any i_data cycle with i_d0[3]==0 (resync).
  - Otherwise increments each i_data cycle and wraps 31->0, so the next packet starts with no gap.
- Header assembly:
  - Offsets 0..23: shift i_d0[2] into the header, LSB first.
  - Offsets 24..31: collect received parity, first bit = P7, last = P0.
- Subpacket assembly (subpacket k):
  - Offsets 0..27: i_d1[k] -> bit 2*offset, i_d2[k] -> bit 2*offset+1.
  - Offsets 28..31: d1 then d2 give parity bits in MSB-first order (P7,P6 at offset 28 ... P1,P0 at offset 31).
- BCH generator: runs per stream over data bits only, one step per bit in transmit order.
  - Step: code' = {code[6:0],0} ^ ((code[7]^bit) ? 8'hC1 : 8'h00).
  - Start value 0 for each packet.
  - A mismatch sets the corresponding error flag.
- Latency: o_pkt_valid pulses exactly one cycle after the offset-31 cycle is sampled. o_pkt_hdr, o_pkt_body and error flags hold until the next pulse.
- o_hsync/o_vsync update from i_d0[1:0] every i_data cycle; they hold when i_data is low.
- Truncation: i_data falls, or a resync occurs, while offset is in 1..31:
  - Pulse o_trunc.
  - Discard the partial packet; no o_pkt_valid.
  - A resync still starts a new packet at offset 0 on the same cycle.
- FSM states: IDLE, COLLECT, EMIT.
  - IDLE->COLLECT when i_data is high.
  - COLLECT->EMIT on a completed packet whose hdr[7:0]==AUDIO_TYPE and !o_hdr_err.
  - COLLECT->IDLE when i_data is low.
  - EMIT: scans k=0..3 over 4 cycles. For each k with hdr[8+k]==1 (and !o_sub_err[k] if DROP_BAD), it drives o_audioL/R and pulses o_sample_valid. No pulse for skipped k.
  - Leaving EMIT: to COLLECT if i_data is high, else IDLE.
  - Collection continues in parallel during EMIT; EMIT uses a snapshot of the packet.
- Non-audio packets (e.g. ACR 0x01, AVI 0x82, audio infoframe 0x84) are reported via o_pkt_valid only.
- Reset mid-packet: the packet is lost, no pulses are generated, and collection restarts at the next i_data rise.

Test Plan:
- Encoder-model AVI packet, header 24'h0D0282, sub0 56'h00000000191046 -> one o_pkt_valid 32 cycles after island start; o_pkt_hdr=0D0282; sub0 matches; o_hdr_err=0, o_sub_err=0; no o_sample_valid.
- Audio packet, header 24'h100302, sub0 L=16'h1234 R=16'hABCD, sub1 L=16'h8000 R=16'h7FFF -> two consecutive o_sample_valid pulses giving (1234,ABCD) then (8000,7FFF).
- Same audio packet with header bit 5 flipped -> o_hdr_err=1 and no samples. Separately, sub1 bit 10 flipped -> o_sub_err=4'b0010 and only the sub0 sample (DROP_BAD=1).
- Back-to-back 64-cycle island (ACR 24'h000001, then audio) -> two o_pkt_valid pulses 32 cycles apart; the second packet uses d0[3]=1 at offset 0 with no resync.
- i_data drops at offset 17 -> o_trunc pulse, no o_pkt_valid. A following clean island decodes normally.
- i_rst_n asserted at offset 10 and released -> all outputs 0; the next island decodes correctly with no spurious pulses.
